// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared defaults and FSM state encoding for the pool scheduler
// Contents: N_REQ_DEF, TIMEOUT_DEF, state_e.
package cnn_pkg;

  localparam int N_REQ_DEF   = 4;
  localparam int TIMEOUT_DEF = 255;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PRST    = 3'd1,
    ST_START   = 3'd2,
    ST_RUN     = 3'd3,
    ST_RELEASE = 3'd4,
    ST_ABORT   = 3'd5
  } state_e;

endpackage

// File: rtl/pool_scheduler_if.sv
// rtl/pool_scheduler_if.sv - requester and pool-engine signal bundle
// master (scheduler): in req, pool_done; out grant, sel, req_done, err, err_id, busy, pool_rst, pool_start.
// slave  (cores + engine): the mirror image.
interface pool_scheduler_if import cnn_pkg::*; #(
  parameter int N_REQ = N_REQ_DEF
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] grant;
  logic [IDX_W-1:0] sel;
  logic [N_REQ-1:0] req_done;
  logic             err;
  logic [IDX_W-1:0] err_id;
  logic             busy;
  logic             pool_rst;
  logic             pool_start;
  logic             pool_done;

  modport master (
    input  req, pool_done,
    output grant, sel, req_done, err, err_id, busy, pool_rst, pool_start
  );

  modport slave (
    output req, pool_done,
    input  grant, sel, req_done, err, err_id, busy, pool_rst, pool_start
  );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at ptr
// in: req[N_REQ], ptr; out: winner (one-hot, zero if no req), winner_idx.
module rr_arbiter import cnn_pkg::*; #(
  parameter  int N_REQ = N_REQ_DEF,
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] winner,
  output logic [IDX_W-1:0] winner_idx
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;
  logic             found;

  // Scan ptr, ptr+1, ... wrapping at N_REQ; the first asserted request wins.
  always_comb begin
    winner     = '0;
    winner_idx = '0;
    found      = 1'b0;
    sum        = '0;
    cand       = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sum = {1'b0, ptr} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(N_REQ)) sum = sum - (IDX_W+1)'(N_REQ);
      cand = sum[IDX_W-1:0];
      if (!found && req[cand]) begin
        found        = 1'b1;
        winner[cand] = 1'b1;
        winner_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/pool_scheduler.sv
// rtl/pool_scheduler.sv - time-shares one pool_layer engine among N_REQ conv cores
// in: clk, rst (sync, active-high), bus.req, bus.pool_done
// out: bus.grant, bus.sel, bus.req_done, bus.err, bus.err_id, bus.busy, bus.pool_rst, bus.pool_start
module pool_scheduler import cnn_pkg::*; #(
  parameter  int N_REQ   = N_REQ_DEF,
  parameter  int TIMEOUT = TIMEOUT_DEF,
  localparam int IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input logic               clk,
  input logic               rst,
  pool_scheduler_if.master  bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TIMEOUT);

  state_e           state;
  logic [IDX_W-1:0] ptr;
  logic [CNT_W-1:0] cnt;
  logic [N_REQ-1:0] win;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] next_ptr;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req        (bus.req),
    .ptr        (ptr),
    .winner     (win),
    .winner_idx (win_idx)
  );

  // sel is the current owner's index; the next search starts just past it.
  assign next_ptr = (bus.sel == IDX_W'(N_REQ - 1)) ? '0 : bus.sel + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      ptr            <= '0;
      cnt            <= '0;
      bus.grant      <= '0;
      bus.sel        <= '0;
      bus.req_done   <= '0;
      bus.err        <= 1'b0;
      bus.err_id     <= '0;
      bus.busy       <= 1'b0;
      // Hold the engine in reset alongside the scheduler.
      bus.pool_rst   <= 1'b1;
      bus.pool_start <= 1'b0;
    end else begin
      // Pulse outputs default low; states below raise them for one cycle.
      bus.req_done   <= '0;
      bus.err        <= 1'b0;
      bus.pool_rst   <= 1'b0;
      bus.pool_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (|bus.req) begin
            state        <= ST_PRST;
            bus.grant    <= win;
            bus.sel      <= win_idx;
            bus.busy     <= 1'b1;
            // The engine sits in DONE after a job; it must be reset to accept a new one.
            bus.pool_rst <= 1'b1;
          end
        end
        ST_PRST: begin
          state          <= ST_START;
          bus.pool_start <= 1'b1;
        end
        ST_START: begin
          state <= ST_RUN;
          cnt   <= '0;
        end
        ST_RUN: begin
          // pool_done is only trusted here; a level left over from the previous job is ignored elsewhere.
          if (bus.pool_done) begin
            state        <= ST_RELEASE;
            bus.req_done <= bus.grant;
          end else if (cnt == CNT_LAST) begin
            state        <= ST_ABORT;
            bus.err      <= 1'b1;
            bus.err_id   <= bus.sel;
            bus.pool_rst <= 1'b1;
          end else if (cnt != CNT_SAT) begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RELEASE, ST_ABORT: begin
          state     <= ST_IDLE;
          bus.grant <= '0;
          bus.busy  <= 1'b0;
          ptr       <= next_ptr;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pool_scheduler.sv
// tb/tb_pool_scheduler.sv - scoreboard bench for pool_scheduler (two timeout settings)
module tb_pool_scheduler;
  import cnn_pkg::*;

  localparam int N   = 4;
  localparam int TB  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pool_scheduler_if #(.N_REQ(N)) bus_a ();
  pool_scheduler_if #(.N_REQ(N)) bus_b ();

  pool_scheduler #(.N_REQ(N), .TIMEOUT(255)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  pool_scheduler #(.N_REQ(N), .TIMEOUT(TB))  dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  typedef enum int {EV_GRANT, EV_DONE, EV_ERR} ev_e;
  typedef struct {
    ev_e        kind;
    logic [3:0] val;
    int         lat;
    bit         b2b;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic rst_at_edge = 1'b1;
  int gcyc[2] = '{0, 0};
  int ecyc[2] = '{-10, -10};
  logic [3:0] pg[2] = '{4'b0, 4'b0};

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= rst;
  end

  task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s dut%0d @cyc %0d: got %0d expected %0d", name, id, cyc, act, exp);
    end
  endtask

  function automatic int oh2i(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic push(input int id, input ev_e k, input logic [3:0] v, input int lat, input bit b2b);
    exp_t e;
    e.kind = k; e.val = v; e.lat = lat; e.b2b = b2b;
    if (id == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic pop(input int id, input string what, output bit ok, output exp_t e);
    ok = 1'b0;
    e.kind = EV_GRANT; e.val = '0; e.lat = 0; e.b2b = 1'b0;
    if (id == 0 && q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
    if (id == 1 && q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL unexpected_%s dut%0d @cyc %0d: event seen, none expected", what, id, cyc);
    end
  endtask

  task automatic mon(input int id, input logic [3:0] grant, input logic [1:0] sel,
                     input logic [3:0] rdone, input logic err, input logic [1:0] eid,
                     input logic busy, input logic prst, input logic pstart);
    exp_t e;
    bit ok;
    if (rst_at_edge) begin
      chk("rst_grant", id, grant, 0);
      chk("rst_sel", id, sel, 0);
      chk("rst_req_done", id, rdone, 0);
      chk("rst_err", id, err, 0);
      chk("rst_err_id", id, eid, 0);
      chk("rst_busy", id, busy, 0);
      chk("rst_pool_start", id, pstart, 0);
      chk("rst_pool_rst", id, prst, 1);
      pg[id] = '0;
      return;
    end
    if (grant != 0 && pg[id] == 0) begin
      pop(id, "grant", ok, e);
      if (ok) begin
        chk("grant_kind", id, e.kind, EV_GRANT);
        chk("grant", id, grant, e.val);
        chk("sel", id, sel, oh2i(e.val));
        chk("grant_pool_rst", id, prst, 1);
        if (e.b2b) chk("b2b_gap", id, cyc, ecyc[id] + 2);
      end
      gcyc[id] = cyc;
    end
    if (pstart) chk("start_lat", id, cyc, gcyc[id] + 1);
    if (rdone != 0) begin
      pop(id, "req_done", ok, e);
      if (ok) begin
        chk("done_kind", id, e.kind, EV_DONE);
        chk("req_done", id, rdone, e.val);
        chk("done_grant_held", id, grant, e.val);
        chk("done_lat", id, cyc, gcyc[id] + e.lat);
      end
      ecyc[id] = cyc;
    end
    if (err) begin
      pop(id, "err", ok, e);
      if (ok) begin
        chk("err_kind", id, e.kind, EV_ERR);
        chk("err_id", id, eid, oh2i(e.val));
        chk("err_pool_rst", id, prst, 1);
        chk("err_no_done", id, rdone, 0);
        chk("err_lat", id, cyc, gcyc[id] + e.lat);
      end
      ecyc[id] = cyc;
    end
    if (cyc == ecyc[id] + 1) begin
      chk("idle_busy", id, busy, 0);
      chk("idle_grant", id, grant, 0);
    end
    pg[id] = grant;
  endtask

  always @(negedge clk) mon(0, bus_a.grant, bus_a.sel, bus_a.req_done, bus_a.err, bus_a.err_id,
                            bus_a.busy, bus_a.pool_rst, bus_a.pool_start);
  always @(negedge clk) mon(1, bus_b.grant, bus_b.sel, bus_b.req_done, bus_b.err, bus_b.err_id,
                            bus_b.busy, bus_b.pool_rst, bus_b.pool_start);

  // Engine models: done rises K RUN cycles after start (K<0: never), holds until pool_rst.
  int ka = -1, kb = -1, cda = -1, cdb = -1;
  int stale_a = 0, stale_seen_a = 0;

  always @(negedge clk) begin
    if (bus_a.pool_rst) begin bus_a.pool_done = 1'b0; cda = -1; end
    else if (bus_a.pool_start) cda = (ka < 0) ? -1 : ka + 1;
    else if (cda > 0) begin cda--; if (cda == 0) bus_a.pool_done = 1'b1; end
    if (stale_a != stale_seen_a) begin stale_seen_a = stale_a; bus_a.pool_done = 1'b1; end
  end

  always @(negedge clk) begin
    if (bus_b.pool_rst) begin bus_b.pool_done = 1'b0; cdb = -1; end
    else if (bus_b.pool_start) cdb = (kb < 0) ? -1 : kb + 1;
    else if (cdb > 0) begin cdb--; if (cdb == 0) bus_b.pool_done = 1'b1; end
  end

  task automatic wait_ev(input int id, input int budget);
    bit hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      hit = (id == 0) ? (bus_a.req_done != 0 || bus_a.err) : (bus_b.req_done != 0 || bus_b.err);
    end
    if (!hit) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_ev dut%0d: no completion within %0d cycles", id, budget);
    end
  endtask

  initial begin
    bus_a.req = '0;
    bus_b.req = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Single job on core 2, done after 40 RUN cycles.
    ka = 40;
    push(0, EV_GRANT, 4'b0100, 0, 0);
    push(0, EV_DONE, 4'b0100, 43, 0);
    bus_a.req = 4'b0100;
    wait_ev(0, 100);
    bus_a.req = '0;
    repeat (4) @(negedge clk);

    // All four cores from reset: served 0,1,2,3 back to back.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ka = 10;
    for (int i = 0; i < 4; i++) begin
      push(0, EV_GRANT, 4'(1 << i), 0, i > 0);
      push(0, EV_DONE, 4'(1 << i), 13, 0);
    end
    bus_a.req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      wait_ev(0, 60);
      bus_a.req = bus_a.req & ~bus_a.req_done;
    end
    repeat (2) @(negedge clk);

    // Cores 0 and 3 held: alternate 0,3,0,3.
    for (int i = 0; i < 4; i++) begin
      push(0, EV_GRANT, (i % 2 == 0) ? 4'b0001 : 4'b1000, 0, i > 0);
      push(0, EV_DONE,  (i % 2 == 0) ? 4'b0001 : 4'b1000, 13, 0);
    end
    bus_a.req = 4'b1001;
    for (int i = 0; i < 4; i++) wait_ev(0, 60);
    bus_a.req = '0;
    repeat (2) @(negedge clk);

    // Stale done held in IDLE, then a job must wait for a fresh done.
    stale_a++;
    repeat (6) @(negedge clk);
    ka = 5;
    push(0, EV_GRANT, 4'b0010, 0, 0);
    push(0, EV_DONE, 4'b0010, 8, 0);
    bus_a.req = 4'b0010;
    wait_ev(0, 60);
    bus_a.req = '0;
    repeat (2) @(negedge clk);

    // Requester drops req early; job still completes.
    ka = 6;
    push(0, EV_GRANT, 4'b0001, 0, 0);
    push(0, EV_DONE, 4'b0001, 9, 0);
    bus_a.req = 4'b0001;
    repeat (2) @(negedge clk);
    bus_a.req = '0;
    wait_ev(0, 60);
    repeat (2) @(negedge clk);

    // Timeout on the TIMEOUT=16 instance, then the pending core 0 is served.
    kb = -1;
    push(1, EV_GRANT, 4'b0100, 0, 0);
    push(1, EV_ERR, 4'b0100, TB + 2, 0);
    bus_b.req = 4'b0100;
    repeat (3) @(negedge clk);
    bus_b.req = 4'b0101;
    wait_ev(1, 60);
    kb = 4;
    bus_b.req = 4'b0001;
    push(1, EV_GRANT, 4'b0001, 0, 1);
    push(1, EV_DONE, 4'b0001, 7, 0);
    wait_ev(1, 60);
    bus_b.req = '0;
    repeat (2) @(negedge clk);

    // Reset in the middle of RUN drops the job; ptr returns to 0.
    ka = -1;
    push(0, EV_GRANT, 4'b0100, 0, 0);
    bus_a.req = 4'b0100;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    bus_a.req = '0;
    @(negedge clk);
    rst = 1'b0;
    ka = 3;
    push(0, EV_GRANT, 4'b0001, 0, 0);
    push(0, EV_DONE, 4'b0001, 6, 0);
    bus_a.req = 4'b1111;
    wait_ev(0, 60);
    bus_a.req = '0;
    repeat (5) @(negedge clk);

    chk("q0_drained", 0, q0.size(), 0);
    chk("q1_drained", 1, q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
